// File: rtl/packet_fifo.sv
// Receive-side packet FIFO behind the SRAM controller's mem2fifo port.
// It shows the head packet first-word-fall-through and drives the controller's full back-pressure flag.
module packet_fifo #(
    parameter int DEPTH        = 8,
    parameter int WIDTH        = 32,
    parameter int AFULL_MARGIN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             replay_iter_flag,
    input  logic             mem2fifo_valid,
    input  logic [WIDTH-1:0] mem2fifo_packet,
    output logic             full,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_packet,
    input  logic             out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - AFULL_MARGIN);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push_accept;
    logic             pop_fire;

    // Push acceptance depends only on the registered count. The margin region still accepts writes, so a read already in flight in the SRAM is not lost.
    assign push_accept = mem2fifo_valid && (count < DEPTH_C);
    assign pop_fire    = out_valid && out_ready;

    assign full       = (count >= THRESH_C);
    assign out_valid  = (count != '0);
    assign out_packet = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!replay_iter_flag && push_accept) begin
            mem[wr_ptr] <= mem2fifo_packet;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (replay_iter_flag) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (mem2fifo_valid && !push_accept) begin
                overflow <= 1'b1;
            end
            case ({push_accept, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_fifo.sv
// Testbench for packet_fifo.
// It applies a directed vector table, hand-written corner sequences, and random traffic checked against a queue model.
module tb_packet_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int AFULL_MARGIN = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             replay_iter_flag;
    logic             mem2fifo_valid;
    logic [WIDTH-1:0] mem2fifo_packet;
    logic             full;
    logic             out_valid;
    logic [WIDTH-1:0] out_packet;
    logic             out_ready;
    logic [$clog2(DEPTH):0] count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit push;
        int data;
        bit rdy;
        bit flush;
        int exp_count;
        bit exp_full;
        bit exp_valid;
        int exp_packet;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[$];

    packet_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_MARGIN(AFULL_MARGIN)) dut (
        .clk(clk),
        .reset(reset),
        .replay_iter_flag(replay_iter_flag),
        .mem2fifo_valid(mem2fifo_valid),
        .mem2fifo_packet(mem2fifo_packet),
        .full(full),
        .out_valid(out_valid),
        .out_packet(out_packet),
        .out_ready(out_ready),
        .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input bit fl, input bit v,
                               input int pkt, input bit ov);
        check({tag, " count"}, 32'(count), 32'(cnt));
        check({tag, " full"}, 32'(full), 32'(fl));
        check({tag, " out_valid"}, 32'(out_valid), 32'(v));
        check({tag, " out_packet"}, out_packet, 32'(pkt));
        check({tag, " overflow"}, 32'(overflow), 32'(ov));
    endtask

    // Inputs are driven 1 time unit after a rising edge. Outputs are then sampled 1 time unit after the next rising edge.
    task automatic step(input bit v, input int data, input bit rdy, input bit fl);
        mem2fifo_valid   = v;
        mem2fifo_packet  = 32'(data);
        out_ready        = rdy;
        replay_iter_flag = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q[$];
        bit model_ovf;
        int head;
        int cnt;

        for (int i = 0; i < 7; i++)
            vecs.push_back('{1'b1, 'h11 + i, 1'b0, 1'b0, i + 1, (i + 1 >= 7), 1'b1, 'h11, 1'b0});
        vecs.push_back('{1'b1, 'h18, 1'b0, 1'b0, 8, 1'b1, 1'b1, 'h11, 1'b0});
        vecs.push_back('{1'b1, 'h19, 1'b0, 1'b0, 8, 1'b1, 1'b1, 'h11, 1'b1});
        for (int k = 1; k <= 8; k++) begin
            cnt = 8 - k;
            vecs.push_back('{1'b0, 0, 1'b1, 1'b0, cnt, (cnt >= 7), (cnt != 0),
                             (cnt != 0) ? 'h11 + k : 0, 1'b1});
        end
        vecs.push_back('{1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1});
        vecs.push_back('{1'b0, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0});

        reset = 1'b0;
        replay_iter_flag = 1'b0;
        mem2fifo_valid = 1'b0;
        mem2fifo_packet = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0);
        check_state("idle", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].data, vecs[i].rdy, vecs[i].flush);
            check_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_full,
                        vecs[i].exp_valid, vecs[i].exp_packet, vecs[i].exp_ovf);
        end

        // Fill to three entries, then push and pop on every cycle so both pointers wrap.
        step(1, 'h21, 0, 0);
        step(1, 'h22, 0, 0);
        step(1, 'h23, 0, 0);
        check_state("fill3", 3, 0, 1, 'h21, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 'h30 + i, 1, 0);
            head = (i == 0) ? 'h22 : (i == 1) ? 'h23 : 'h30 + i - 2;
            check_state($sformatf("stream%0d", i), 3, 0, 1, head, 0);
        end

        step(1, 'h40, 0, 0);
        step(1, 'h41, 0, 0);
        check("pre-flush count", 32'(count), 5);
        step(1, 'hAA, 1, 1);
        check_state("flush", 0, 0, 0, 0, 0);
        step(1, 'hBB, 0, 0);
        check_state("post-flush push", 1, 0, 1, 'hBB, 0);

        step(1, 'h61, 0, 0);
        step(1, 'h62, 0, 0);
        step(1, 'h63, 0, 0);
        check("pre-reset count", 32'(count), 4);
        #3 reset = 1'b0;
        #1;
        check("async reset count", 32'(count), 0);
        check("async reset valid", 32'(out_valid), 0);
        #2 reset = 1'b1;
        step(1, 'h5A, 0, 0);
        check_state("post-reset push", 1, 0, 1, 'h5A, 0);

        // Random traffic: reset to a known empty state, then compare every cycle with a queue model.
        reset = 1'b0;
        #2 reset = 1'b1;
        q.delete();
        model_ovf = 0;
        for (int c = 0; c < 2000; c++) begin
            bit v, r, f, pop_ok, push_ok;
            int d;
            v = ($urandom_range(99) < ((c / 200) % 2 ? 40 : 75));
            r = ($urandom_range(99) < ((c / 200) % 2 ? 75 : 35));
            f = ($urandom_range(99) < 2);
            d = int'($urandom);
            if (f) begin
                q.delete();
                model_ovf = 0;
            end else begin
                pop_ok  = (q.size() != 0) && r;
                push_ok = v && (q.size() < DEPTH);
                if (v && !push_ok) model_ovf = 1;
                if (pop_ok) void'(q.pop_front());
                if (push_ok) q.push_back(d);
            end
            step(v, d, r, f);
            check_state($sformatf("rand%0d", c), q.size(), (q.size() >= DEPTH - AFULL_MARGIN),
                        (q.size() != 0), (q.size() != 0) ? q[0] : 0, model_ovf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_fifo.md
Name: packet_fifo

Overview:
- Receive-side buffer at the far end of the mem2fifo / full interface of the packet SRAM controller.
- Accepts one packet per cycle from the controller's mem2fifo output and drives the full back-pressure flag the controller samples before every SRAM read.
- Presents packets first-word-fall-through to the downstream PE dispatcher with a valid/ready handshake.
- Cleared on replay_iter_flag so a new replay iteration starts with an empty queue.

Parameters:
- DEPTH, 8: number of packet entries; power of two, at least 4.
- WIDTH, `packet_size: packet width in bits.
- AFULL_MARGIN, 1: full asserts when occupancy >= DEPTH - AFULL_MARGIN; range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; state clears immediately while reset is 0.
- replay_iter_flag  in  1  synchronous flush of all contents.
- mem2fifo_valid  in  1  push strobe (com_packet.valid).
- mem2fifo_packet  in  WIDTH  push data (com_packet.packet).
- full  out  1  back-pressure to the controller; combinational from registered count only.
- out_valid  out  1  head entry is valid.
- out_packet  out  WIDTH  head entry data; zero when empty.
- out_ready  in  1  downstream accepts the head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky error: a push was dropped.

Behaviour:
- Storage: DEPTH x WIDTH register array with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. count is a separate register from 0 to DEPTH.
- Reset (reset=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, overflow=0.
  - Outputs during and after reset: full=0 (when DEPTH-AFULL_MARGIN>0), out_valid=0, out_packet=0.
  - Array contents are don't-care.
- full = (count >= DEPTH-AFULL_MARGIN). It has no combinational path from mem2fifo_valid or out_ready, so there is no loop with the controller's read decision.
- Push accept = mem2fifo_valid && (count < DEPTH).
  - On accept: mem[wr_ptr] <= packet; wr_ptr+1.
  - A push while count==DEPTH is dropped and sets overflow=1; overflow is sticky until reset or flush.
  - A push while full=1 but count<DEPTH (margin region) is accepted. This absorbs the in-flight SRAM read the controller issued before it saw full.
- Pop: out_valid = (count != 0); out_packet = mem[rd_ptr] when out_valid, else 0.
  - Pop fire = out_valid && out_ready; on fire rd_ptr+1.
  - out_ready while empty is ignored.
- Count update:
  - push accept only: +1.
  - pop fire only: -1.
  - both: unchanged; the write and read go to different entries, or the same entry when count==0 is impossible because pop requires count>0.
- Simultaneous push and pop at count==DEPTH: the push is dropped, because acceptance uses the registered count. overflow is set and the pop proceeds.
- Latency: a packet pushed in cycle N appears on out_packet with out_valid=1 in cycle N+1 if the FIFO was empty.
- Ordering: strict FIFO order; no reordering and no duplication.
- Flush (replay_iter_flag=1 at a rising edge): rd_ptr=0, wr_ptr=0, count=0, overflow=0.
  - Flush has priority over push and pop in the same cycle: the concurrent push is discarded, not counted as overflow, and a pop that cycle is not consumed.
- Reset asserted mid-operation: state clears immediately without waiting for a clock edge. After deassertion the first push is stored at entry 0.
- AFULL_MARGIN=0: full asserts exactly at count==DEPTH.

Test Plan:
- Reset then idle, DEPTH=8: full=0, out_valid=0, out_packet=0, count=0, overflow=0.
- Push 0x11..0x17 (7 packets) with out_ready=0: count=7 and full=1 after the 7th push. An 8th push of 0x18 is accepted, giving count=8. A 9th push of 0x19 is dropped, overflow=1, count stays 8.
- Then out_ready=1 for 8 cycles: out_packet reads 0x11..0x18 in order, out_valid drops after 0x18, and full falls to 0 once count reaches 6.
- Continuous push and pop every cycle for 20 cycles starting from count=3: count stays 3, no overflow. Data order is preserved across pointer wrap (rd_ptr and wr_ptr wrap past 7).
- replay_iter_flag pulsed while count=5 together with a push of 0xAA and out_ready=1: next cycle count=0, out_valid=0, overflow=0. The next push of 0xBB appears as the head one cycle later.
- reset driven 0 asynchronously between clock edges while count=4: count=0 and out_valid=0 before the next edge. After release, push 0x5A yields out_packet=0x5A, count=1.
